// File: rtl/ym2610_pkg.sv
// Shared constants and types for the YM2610 serial DAC receiver.
package ym2610_pkg;
  localparam int WORD_BITS = 16;
  localparam int MANT_LSB  = 3;
  localparam int MANT_W    = 10;
  localparam int EXP_LSB   = 13;
  localparam int EXP_W     = 3;

  typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} rx_state_t;
endpackage

// File: rtl/ym_float_decode.sv
// Combinational YM3016-format float word to signed 16-bit linear PCM.
module ym_float_decode
  import ym2610_pkg::*;
(
  input  logic [15:0] word_i,
  output logic [15:0] pcm_o
);
  logic [MANT_W-1:0] mant;
  logic [EXP_W-1:0]  expo;
  logic [15:0]       mant_sx;
  logic              unused_ok;

  // Mantissa is offset binary: flipping the MSB yields two's complement.
  assign mant      = word_i[MANT_LSB +: MANT_W] ^ 10'h200;
  assign expo      = word_i[EXP_LSB +: EXP_W];
  assign mant_sx   = {{(16-MANT_W){mant[MANT_W-1]}}, mant};
  assign unused_ok = &{1'b0, word_i[MANT_LSB-1:0]};

  always_comb begin
    pcm_o = 16'h0000;
    if (expo != '0) pcm_o = mant_sx << (expo - 3'd1);
  end
endmodule

// File: rtl/ym2610_dac_rx.sv
// Captures the YM2610 serial DAC stream and emits decoded L/R PCM pairs.
module ym2610_dac_rx #(
  parameter int WORD_BITS   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        dac_clk_in,
  input  logic        dac_data_in,
  input  logic        dac_sh1_in,
  input  logic        dac_sh2_in,
  output logic [15:0] sample_left,
  output logic [15:0] sample_right,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun,
  output logic        frame_error,
  input  logic        status_clear
);
  import ym2610_pkg::*;

  // Bit order in sync vectors: 0 dclk, 1 data, 2 sh1, 3 sh2.
  logic [SYNC_STAGES-1:0][3:0] sync_q, sync_d;
  logic [3:0] sync_out;
  logic [2:0] last_q, last_d, ev_q, ev_d;
  logic       data_q, data_d;

  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [4:0]           bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [15:0]          left_hold_q, left_hold_d, dec_word;
  logic                 pending_q, pending_d;
  rx_state_t            state_q, state_d;

  logic [15:0] left_q, left_d, right_q, right_d;
  logic        valid_q, valid_d, overrun_q, overrun_d, ferr_q, ferr_d;
  logic        dclk_rise, sh1_fall, sh2_fall, word_ok, pair_form, frame_set;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign dclk_rise = ev_q[0];
  assign sh1_fall  = ev_q[1];
  assign sh2_fall  = ev_q[2];

  always_comb begin
    sync_d[0] = {dac_sh2_in, dac_sh1_in, dac_data_in, dac_clk_in};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    last_d = {sync_out[3], sync_out[2], sync_out[0]};
    ev_d   = {last_q[2] & ~sync_out[3], last_q[1] & ~sync_out[2], ~last_q[0] & sync_out[0]};
    data_d = sync_out[1];
  end

  // A bit captured alongside a strobe still belongs to the word being closed.
  always_comb begin
    shift_d   = dclk_rise ? {data_q, shift_q[WORD_BITS-1:1]} : shift_q;
    cnt_inc   = (dclk_rise && bit_cnt_q != 5'd31) ? bit_cnt_q + 5'd1 : bit_cnt_q;
    bit_cnt_d = (sh1_fall || sh2_fall) ? 5'd0 : cnt_inc;
    word_ok   = (cnt_inc == 5'(WORD_BITS));
  end

  ym_float_decode u_dec (.word_i(shift_d), .pcm_o(dec_word));

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!enable)                         state_d = ALIGN;
    else if (state_q == ALIGN && sh2_fall) state_d = RUN;
  end

  // FSM outputs
  always_comb begin
    left_hold_d = left_hold_q;
    pending_d   = pending_q;
    pair_form   = 1'b0;
    frame_set   = 1'b0;
    if (!enable || state_q == ALIGN) begin
      pending_d = 1'b0;
    end else if (sh1_fall && sh2_fall) begin
      frame_set = 1'b1;
      pending_d = 1'b0;
    end else if (sh1_fall) begin
      if (word_ok) begin
        left_hold_d = dec_word;
        pending_d   = 1'b1;
      end else begin
        frame_set = 1'b1;
        pending_d = 1'b0;
      end
    end else if (sh2_fall) begin
      pair_form = word_ok && pending_q;
      frame_set = !word_ok;
      pending_d = 1'b0;
    end
  end

  always_comb begin
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = valid_q && !sample_ready;
    overrun_d = overrun_q && !status_clear;
    ferr_d    = (ferr_q && !status_clear) || frame_set;
    if (pair_form) begin
      if (!valid_q || sample_ready) begin
        left_d  = left_hold_q;
        right_d = dec_word;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '0;
      last_q      <= '0;
      ev_q        <= '0;
      data_q      <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      left_hold_q <= '0;
      pending_q   <= 1'b0;
      state_q     <= ALIGN;
      left_q      <= '0;
      right_q     <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      last_q      <= last_d;
      ev_q        <= ev_d;
      data_q      <= data_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      left_hold_q <= left_hold_d;
      pending_q   <= pending_d;
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
      ferr_q      <= ferr_d;
    end
  end

  assign sample_left  = left_q;
  assign sample_right = right_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;
  assign frame_error  = ferr_q;
endmodule
